// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end types and constants.
// Includes the fetch-queue entry layout and the canonical NOP.
package riscv_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            btaken;
    } fq_entry_t;

endpackage : riscv_pkg

// File: rtl/instr_fetch_queue_if.sv
// Bundle of the fetch-queue handshake signals.
// master = fetch/decode side, slave = the queue.
interface instr_fetch_queue_if #(
    parameter int DEPTH = 4
);
    import riscv_pkg::*;

    logic                     flush;
    logic                     enq_valid;
    logic                     enq_ready;
    logic [XLEN-1:0]          enq_pc;
    logic [XLEN-1:0]          enq_instr;
    logic                     enq_btaken;
    logic                     deq_valid;
    logic                     deq_ready;
    logic [XLEN-1:0]          deq_pc;
    logic [XLEN-1:0]          deq_instr;
    logic                     deq_btaken;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output flush, enq_valid, enq_pc, enq_instr, enq_btaken, deq_ready,
        input  enq_ready, deq_valid, deq_pc, deq_instr, deq_btaken, count
    );

    modport slave (
        input  flush, enq_valid, enq_pc, enq_instr, enq_btaken, deq_ready,
        output enq_ready, deq_valid, deq_pc, deq_instr, deq_btaken, count
    );

endinterface : instr_fetch_queue_if

// File: rtl/instr_fetch_queue.sv
// First-word-fall-through instruction fetch queue between fetch and decode.
// Flush drops everything for a redirect; empty output presents a NOP.
module instr_fetch_queue
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   enq_valid_i,
    output logic                   enq_ready_o,
    input  logic [XLEN-1:0]        enq_pc_i,
    input  logic [XLEN-1:0]        enq_instr_i,
    input  logic                   enq_btaken_i,
    output logic                   deq_valid_o,
    input  logic                   deq_ready_i,
    output logic [XLEN-1:0]        deq_pc_o,
    output logic [XLEN-1:0]        deq_instr_o,
    output logic                   deq_btaken_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fq_entry_t       r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic            w_enq;
    logic            w_deq;
    logic            w_wr_en;
    fq_entry_t       w_head;

    // Ready depends only on the registered count, so full blocks enqueue
    // even when decode is draining in the same cycle.
    assign enq_ready_o = (r_count < CW'(DEPTH));
    assign deq_valid_o = (r_count != '0);
    assign w_enq       = enq_valid_i && enq_ready_o;
    assign w_deq       = deq_valid_o && deq_ready_i;
    assign w_wr_en     = w_enq && !flush_i && !rst_i;

    assign w_head       = r_mem[r_rd_ptr];
    assign deq_pc_o     = deq_valid_o ? w_head.pc     : '0;
    assign deq_instr_o  = deq_valid_o ? w_head.instr  : NOP_INSTR;
    assign deq_btaken_o = deq_valid_o ? w_head.btaken : 1'b0;
    assign count_o      = r_count;

    always_ff @(posedge clk_i) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= '{pc: enq_pc_i, instr: enq_instr_i, btaken: enq_btaken_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : instr_fetch_queue

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning queue entries; power of two, at least 2.
REQ-002 SHALL use XLEN from riscv_pkg, meaning PC and instruction width (32).
REQ-003 SHALL have the following ports, in this order:
- clk_i  in  1  sole clock; all state updates on its rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- flush_i  in  1  discard all entries (wrong-branch redirect).
- enq_valid_i  in  1  fetch offers an entry.
- enq_ready_o  out  1  queue can accept an entry.
- enq_pc_i  in  XLEN  PC of the offered instruction.
- enq_instr_i  in  XLEN  offered instruction word.
- enq_btaken_i  in  1  predictor hit/taken flag for the offered instruction.
- deq_valid_o  out  1  head entry is valid.
- deq_ready_i  in  1  decode accepts the head entry (not stalled).
- deq_pc_o  out  XLEN  head PC.
- deq_instr_o  out  XLEN  head instruction.
- deq_btaken_o  out  1  head predictor flag.
- count_o  out  $clog2(DEPTH)+1  current occupancy.

Function
REQ-004 SHALL be a first-word-fall-through FIFO: head data is visible on deq_* in the same cycle deq_valid_o is high.
REQ-005 SHALL perform an enqueue when enq_valid_i && enq_ready_o; the entry is stored at the edge.
REQ-006 SHALL perform a dequeue when deq_valid_o && deq_ready_i; the head advances at the edge.
REQ-007 SHALL drive enq_ready_o = (count < DEPTH), depending only on registered state, with no combinational path from deq_ready_i.
REQ-008 SHALL drive deq_valid_o = (count != 0).
REQ-009 SHALL drive deq_pc_o = 0, deq_instr_o = 32'h0000_0013 (NOP) and deq_btaken_o = 0 when empty.
REQ-010 SHALL have a minimum latency of 1 cycle: an entry enqueued at edge N is presented at the output after edge N.
REQ-011 SHALL, on simultaneous enqueue and dequeue, leave count unchanged and advance both pointers; this applies when empty is excluded by REQ-008.
REQ-012 SHALL refuse enqueue when full (enq_ready_o = 0), even if a dequeue occurs in the same cycle.
REQ-013 SHALL wrap the read and write pointers modulo DEPTH, with no lost or duplicated entries across the wrap.
REQ-014 SHALL, on flush_i, set count and both pointers to 0 at the next edge.
REQ-015 SHALL give flush_i priority over enqueue and dequeue in the same cycle; the offered entry is dropped.
REQ-016 SHALL keep count_o exact at all times: enq-only +1, deq-only -1, both or neither unchanged.
REQ-017 SHALL have no requirement on storage contents outside the valid entries.

Reset
REQ-018 SHALL, while rst_i is high at an edge, set count = 0 and pointers = 0, giving enq_ready_o = 1, deq_valid_o = 0, deq outputs at the NOP values of REQ-009, and count_o = 0.
REQ-019 SHALL give reset priority over flush_i, enqueue and dequeue; a reset mid-stream discards all entries.
REQ-020 SHALL NOT need to reset the storage array.

Structure
REQ-021 SHALL take XLEN and a NOP constant (NOP_INSTR = 32'h0000_0013) from riscv_pkg; the constant is added to riscv_pkg if absent.
REQ-022 SHALL hold each entry as a packed struct fq_entry_t {pc, instr, btaken}, defined in riscv_pkg.
REQ-023 SHALL be a single module with no sub-modules; the storage is an array of fq_entry_t indexed by the pointers.

Verification
REQ-024 Reset: assert rst_i for 2 cycles -> enq_ready_o = 1, deq_valid_o = 0, deq_instr_o = 0x00000013, count_o = 0.
REQ-025 Fill/drain with deq_ready_i = 0: enqueue PCs 0x0, 0x4, 0x8, 0xC -> count_o = 4 and enq_ready_o = 0; a fifth offer (0x10) is not accepted; then deq_ready_i = 1 -> outputs 0x0, 0x4, 0x8, 0xC on consecutive cycles, then empty.
REQ-026 Streaming: enqueue and dequeue every cycle for 10 entries -> count_o stays 1 after the first cycle, order is preserved, and pointers wrap twice with no loss.
REQ-027 Flush: with 3 entries queued, assert flush_i together with enq_valid_i (PC 0x40) -> next cycle count_o = 0, deq_valid_o = 0, and 0x40 is never output.
REQ-028 Full plus simultaneous dequeue: at count 4 with enq_valid_i = 1 and deq_ready_i = 1 -> next cycle count_o = 3 and the offered entry is not stored.
REQ-029 Reset mid-operation: with 2 entries queued, assert rst_i with enq_valid_i = 1 -> next cycle empty, and the btaken flags of earlier entries never appear.
